// File: rtl/track_scheduler.sv
// track_scheduler
// Sequences the shared RAM port once per audio sample period: one read per
// played track (ascending index), then an optional write of the record
// sample. The reads are summed and the sum is saturated to 16 bits for the
// mix output. Every output is registered.
module track_scheduler #(
    parameter int TRACKS = 4,
    parameter int TRK_W  = 2,
    parameter int POS_W  = 21,
    parameter int ADDR_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic              rec_en,
    input  logic [TRK_W-1:0]  rec_track,
    input  logic [15:0]       rec_sample,
    input  logic [TRACKS-1:0] play_mask,
    input  logic [POS_W-1:0]  loop_len,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       mix_out,
    output logic              mix_valid,
    output logic [POS_W-1:0]  pos,
    output logic              busy,
    output logic              overrun
);

    localparam int ACC_W = 16 + TRK_W;
    localparam logic [TRK_W-1:0]        LAST_IDX = TRK_W'(TRACKS - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_LO   = ACC_W'(-32'sd32768);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Clamp the wide accumulator into the signed 16-bit output range.
    function automatic logic [15:0] saturate(input logic signed [ACC_W-1:0] a);
        logic [15:0] r;
        if (a > SAT_HI) begin
            r = 16'h7FFF;
        end else if (a < SAT_LO) begin
            r = 16'h8000;
        end else begin
            r = a[15:0];
        end
        return r;
    endfunction

    state_t                    state_r;
    state_t                    state_s;

    // Snapshot taken at the tick so a period is immune to live input changes.
    logic [TRACKS-1:0]         mask_r;
    logic                      rec_en_r;
    logic [TRK_W-1:0]          rec_track_r;
    logic [15:0]               rec_sample_r;

    logic [TRK_W-1:0]          idx_r;
    logic signed [ACC_W-1:0]   acc_r;
    logic signed [ACC_W-1:0]   acc_s;
    logic signed [ACC_W-1:0]   rdata_ext_s;
    logic [POS_W-1:0]          pos_r;
    logic [POS_W-1:0]          pos_s;

    logic                      mem_req_r;
    logic                      mem_we_r;
    logic [ADDR_W-1:0]         mem_addr_r;
    logic [15:0]               mem_wdata_r;
    logic [15:0]               mix_out_r;
    logic                      mix_valid_r;
    logic                      busy_r;
    logic                      overrun_r;

    logic                      ack_s;
    logic                      hit_s;
    logic                      last_s;
    logic                      req_s;
    logic                      load_s;
    logic                      we_s;
    logic [ADDR_W-1:0]         addr_s;
    logic [15:0]               wdata_s;
    logic                      mix_upd_s;
    logic                      idx_inc_s;

    // Qualify the handshake and decode the scan position.
    always_comb begin
        ack_s  = mem_ack & mem_req_r;
        hit_s  = mask_r[idx_r];
        last_s = (idx_r == LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the last read jumps straight on so scanning costs
    // exactly one cycle per track index.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sample_tick) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (hit_s) begin
                    state_s = ST_READ;
                end else if (last_s) begin
                    state_s = rec_en_r ? ST_WRITE : ST_DONE;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_READ: begin
                if (ack_s && last_s) begin
                    state_s = rec_en_r ? ST_WRITE : ST_DONE;
                end else if (ack_s) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_WRITE: begin
                if (ack_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: accumulate on read acks, compute the next position.
    always_comb begin
        rdata_ext_s = {{TRK_W{mem_rdata[15]}}, mem_rdata};
        if ((state_r == ST_READ) && ack_s) begin
            acc_s = acc_r + rdata_ext_s;
        end else begin
            acc_s = acc_r;
        end
        // Covers a live shrink of loop_len below pos; loop_len 0 wraps naturally.
        if ((loop_len != {POS_W{1'b0}}) && (pos_r >= (loop_len - POS_W'(1)))) begin
            pos_s = {POS_W{1'b0}};
        end else begin
            pos_s = pos_r + POS_W'(1);
        end
        idx_inc_s = ((state_r == ST_SCAN) && !hit_s) || ((state_r == ST_READ) && ack_s);
    end

    // Output decode: request held from one cycle after entering READ/WRITE
    // until the ack cycle; port fields are captured once at request rise.
    always_comb begin
        req_s     = ((state_r == ST_READ) || (state_r == ST_WRITE)) && (state_s == state_r);
        load_s    = req_s && !mem_req_r;
        we_s      = (state_r == ST_WRITE);
        mix_upd_s = (state_s == ST_DONE);
        if (state_r == ST_WRITE) begin
            addr_s  = ADDR_W'({rec_track_r, pos_r});
            wdata_s = rec_sample_r;
        end else begin
            addr_s  = ADDR_W'({idx_r, pos_r});
            wdata_s = mem_wdata_r;
        end
    end

    // Snapshot, scan index and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r       <= {TRACKS{1'b0}};
            rec_en_r     <= 1'b0;
            rec_track_r  <= {TRK_W{1'b0}};
            rec_sample_r <= 16'h0000;
            idx_r        <= {TRK_W{1'b0}};
            acc_r        <= {ACC_W{1'b0}};
        end else if ((state_r == ST_IDLE) && sample_tick) begin
            mask_r       <= play_mask;
            rec_en_r     <= rec_en;
            rec_track_r  <= rec_track;
            rec_sample_r <= rec_sample;
            idx_r        <= {TRK_W{1'b0}};
            acc_r        <= {ACC_W{1'b0}};
        end else begin
            acc_r <= acc_s;
            if (idx_inc_s) begin
                idx_r <= idx_r + TRK_W'(1);
            end
        end
    end

    // RAM port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 16'h0000;
        end else begin
            mem_req_r <= req_s;
            if (load_s) begin
                mem_we_r    <= we_s;
                mem_addr_r  <= addr_s;
                mem_wdata_r <= wdata_s;
            end
        end
    end

    // Mix, position, busy and sticky overrun registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mix_out_r   <= 16'h0000;
            mix_valid_r <= 1'b0;
            pos_r       <= {POS_W{1'b0}};
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            mix_valid_r <= mix_upd_s;
            busy_r      <= (state_s != ST_IDLE);
            if (mix_upd_s) begin
                mix_out_r <= saturate(acc_s);
            end
            if (state_r == ST_DONE) begin
                pos_r <= pos_s;
            end
            if (sample_tick && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mix_out   = mix_out_r;
    assign mix_valid = mix_valid_r;
    assign pos       = pos_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_track_scheduler.sv
// Bench for track_scheduler: a period-level model predicts the transaction
// list, mix, busy window and position for each accepted tick; a per-cycle
// checker compares the DUT against it while a small RAM responder acks.
module tb_track_scheduler;

    localparam int TRACKS = 4;
    localparam int TRK_W  = 2;
    localparam int POS_W  = 21;
    localparam int ADDR_W = 23;

    logic              clk;
    logic              rst;
    logic              sample_tick;
    logic              rec_en;
    logic [TRK_W-1:0]  rec_track;
    logic [15:0]       rec_sample;
    logic [TRACKS-1:0] play_mask;
    logic [POS_W-1:0]  loop_len;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic [15:0]       mix_out;
    logic              mix_valid;
    logic [POS_W-1:0]  pos;
    logic              busy;
    logic              overrun;

    track_scheduler #(
        .TRACKS(TRACKS), .TRK_W(TRK_W), .POS_W(POS_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .rec_en(rec_en),
        .rec_track(rec_track), .rec_sample(rec_sample), .play_mask(play_mask),
        .loop_len(loop_len), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mix_out(mix_out), .mix_valid(mix_valid),
        .pos(pos), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       wdata;
    } tx_t;

    int n_cmp  = 0;
    int n_fail = 0;

    // RAM responder controls and contents (value returned per track)
    int   rd_val [TRACKS];
    int   lat;
    logic resp_en;
    logic stale_ack;
    int   cnt;

    // model state
    int                rem;
    logic              ov_m;
    logic [POS_W-1:0]  pos_m;
    logic [15:0]       mix_m;
    logic [15:0]       pend_mix;
    tx_t               txq[$];
    tx_t               cur;
    logic              prev_req;
    logic              ack_pending;

    // observation logs
    int                mv_count;
    logic [15:0]       last_mix;
    logic [ADDR_W-1:0] log_addr[$];
    logic              log_we[$];
    logic [15:0]       log_wdata[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input int s);
        logic [31:0] v;
        v = s;
        if (s > 32767) return 16'h7FFF;
        else if (s < -32768) return 16'h8000;
        else return v[15:0];
    endfunction

    function automatic logic [ADDR_W-1:0] mk_addr(input int trk, input logic [POS_W-1:0] p);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(trk) << POS_W;
        a = a | ADDR_W'(p);
        return a;
    endfunction

    function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] p, input logic [POS_W-1:0] ll);
        int np;
        np = int'(p) + 1;
        if (ll == 0) return POS_W'(np);
        else if (np >= int'(ll)) return '0;
        else return POS_W'(np);
    endfunction

    // Model update at each edge, checks 1 time unit later, then RAM responder.
    initial begin
        int   rem_before;
        int   sum;
        int   ntx;
        tx_t  tx;
        rem = 0; ov_m = 1'b0; pos_m = '0; mix_m = 16'h0000; pend_mix = 16'h0000;
        prev_req = 1'b0; ack_pending = 1'b0; cnt = 0; mv_count = 0; last_mix = 16'h0000;
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            if (rst) begin
                rem = 0; ov_m = 1'b0; pos_m = '0; mix_m = 16'h0000;
                txq.delete();
            end else begin
                rem_before = rem;
                if (rem > 0) begin
                    rem--;
                    if (rem == 0) pos_m = next_pos(pos_m, loop_len);
                end
                if (sample_tick) begin
                    if (rem_before > 0) begin
                        ov_m = 1'b1;
                    end else begin
                        sum = 0; ntx = 0; txq.delete();
                        for (int t = 0; t < TRACKS; t++) begin
                            if (play_mask[t]) begin
                                tx.we = 1'b0; tx.addr = mk_addr(t, pos_m); tx.wdata = 16'h0000;
                                txq.push_back(tx);
                                sum += rd_val[t];
                                ntx++;
                            end
                        end
                        if (rec_en) begin
                            tx.we = 1'b1; tx.addr = mk_addr(int'(rec_track), pos_m); tx.wdata = rec_sample;
                            txq.push_back(tx);
                            ntx++;
                        end
                        pend_mix = sat16(sum);
                        rem = TRACKS + 1 + ntx * (lat + 1);
                    end
                end
                if (rem == 1) mix_m = pend_mix;
            end
            #1;
            chk("busy", 32'(busy), 32'(rem > 0));
            chk("mix_valid", 32'(mix_valid), 32'(rem == 1));
            chk("overrun", 32'(overrun), 32'(ov_m));
            chk("pos", 32'(pos), 32'(pos_m));
            chk("mix_out", 32'(mix_out), 32'(mix_m));
            if (rem == 0) chk("idle_req", 32'(mem_req), 32'd0);
            if (ack_pending) chk("req_drop", 32'(mem_req), 32'd0);
            if (mem_req && !prev_req) begin
                if (txq.size() == 0) begin
                    chk("req_unexpected", 32'(mem_req), 32'd0);
                end else begin
                    cur = txq.pop_front();
                    chk("tx_we", 32'(mem_we), 32'(cur.we));
                    chk("tx_addr", 32'(mem_addr), 32'(cur.addr));
                    if (cur.we) chk("tx_wdata", 32'(mem_wdata), 32'(cur.wdata));
                end
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_we);
                log_wdata.push_back(mem_wdata);
            end else if (mem_req && prev_req) begin
                chk("hold_we", 32'(mem_we), 32'(cur.we));
                chk("hold_addr", 32'(mem_addr), 32'(cur.addr));
                if (cur.we) chk("hold_wdata", 32'(mem_wdata), 32'(cur.wdata));
            end
            if (rem == 1) chk("tx_left", 32'(txq.size()), 32'd0);
            if (mix_valid) begin
                mv_count++;
                last_mix = mix_out;
            end
            prev_req = mem_req;
            // responder
            if (!resp_en) begin
                mem_ack = stale_ack;
                mem_rdata = 16'h7777;
                cnt = 0;
                ack_pending = 1'b0;
            end else begin
                if (mem_req && !mem_ack) begin
                    cnt++;
                    if (cnt >= lat) begin
                        mem_ack = 1'b1;
                        mem_rdata = 16'(rd_val[int'(mem_addr[ADDR_W-1:POS_W])]);
                        cnt = 0;
                    end
                end else begin
                    mem_ack = 1'b0;
                    cnt = 0;
                end
                ack_pending = mem_ack && mem_req;
            end
        end
    end

    task automatic do_tick();
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic run_period(input string name);
        log_addr.delete(); log_we.delete(); log_wdata.delete();
        do_tick();
        wait_idle(name);
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        logic [POS_W-1:0] seq [7];
        int mv0;
        logic seen;
        seq = '{21'd1, 21'd2, 21'd0, 21'd1, 21'd2, 21'd0, 21'd1};
        rst = 1'b1; sample_tick = 1'b0; rec_en = 1'b0; rec_track = 2'd0;
        rec_sample = 16'h0000; play_mask = 4'b0000; loop_len = '0;
        resp_en = 1'b1; stale_ack = 1'b0; lat = 3;
        for (int t = 0; t < TRACKS; t++) rd_val[t] = 0;

        // reset then idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("idle_mem_req", 32'(mem_req), 32'd0);
        chk("idle_pos", 32'(pos), 32'd0);
        chk("idle_mix", 32'(mix_out), 32'd0);
        chk("idle_addr", 32'(mem_addr), 32'd0);

        // two-track read
        rd_val[0] = 1000; rd_val[2] = -300; play_mask = 4'b0101;
        run_period("t2_timeout");
        chk("t2_mix", 32'(last_mix), 32'd700);
        chk("t2_pos", 32'(pos), 32'd1);
        chk("t2_ntx", 32'(log_addr.size()), 32'd2);
        chk("t2_a0", 32'(log_addr[0]), 32'h000000);
        chk("t2_a1", 32'(log_addr[1]), 32'h400000);

        // saturation high with overdub
        rd_val[0] = 30000; rd_val[1] = 30000; play_mask = 4'b0011;
        rec_en = 1'b1; rec_track = 2'd1; rec_sample = 16'h1234;
        run_period("sat_timeout");
        chk("sat_mix", 32'(last_mix), 32'h7FFF);
        chk("sat_ntx", 32'(log_addr.size()), 32'd3);
        chk("sat_a0", 32'(log_addr[0]), 32'h000001);
        chk("sat_a1", 32'(log_addr[1]), 32'h200001);
        chk("sat_wa", 32'(log_addr[2]), 32'h200001);
        chk("sat_we", 32'(log_we[2]), 32'd1);
        chk("sat_wd", 32'(log_wdata[2]), 32'h1234);

        // saturation low
        rd_val[0] = -30000; rd_val[1] = -30000;
        run_period("satn_timeout");
        chk("satn_mix", 32'(last_mix), 32'h8000);
        chk("satn_pos", 32'(pos), 32'd3);

        // empty mask, no record: no traffic
        play_mask = 4'b0000; rec_en = 1'b0;
        run_period("empty_timeout");
        chk("empty_mix", 32'(mix_out), 32'd0);
        chk("empty_ntx", 32'(log_addr.size()), 32'd0);
        chk("empty_pos", 32'(pos), 32'd4);

        // record only
        rec_en = 1'b1; rec_track = 2'd3; rec_sample = 16'hBEEF;
        run_period("reco_timeout");
        chk("reco_ntx", 32'(log_addr.size()), 32'd1);
        chk("reco_addr", 32'(log_addr[0]), 32'h600004);
        chk("reco_wd", 32'(log_wdata[0]), 32'hBEEF);
        chk("reco_pos", 32'(pos), 32'd5);
        rec_en = 1'b0;

        // reset, then loop wrap
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("rst_pos", 32'(pos), 32'd0);
        loop_len = 21'd3; play_mask = 4'b0001; rd_val[0] = 100; lat = 1;
        mv0 = mv_count;
        for (int k = 0; k < 7; k++) begin
            run_period("loop_timeout");
            chk("loop_pos", 32'(pos), 32'(seq[k]));
        end
        chk("loop_mv", 32'(mv_count - mv0), 32'd7);
        chk("loop_mix", 32'(last_mix), 32'd100);

        // live shrink below pos
        loop_len = 21'd1;
        run_period("live_timeout");
        chk("live_pos", 32'(pos), 32'd0);
        loop_len = '0;

        // overrun
        lat = 50; rd_val[0] = 5; mv0 = mv_count;
        do_tick();
        repeat (10) @(negedge clk);
        do_tick();
        wait_idle("ovr_timeout");
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_mv", 32'(mv_count - mv0), 32'd1);
        chk("ovr_pos", 32'(pos), 32'd1);
        chk("ovr_mix", 32'(last_mix), 32'd5);

        // reset mid-read, then a stale ack
        lat = 20;
        do_tick();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rm_req_seen", 32'(seen), 32'd1);
        resp_en = 1'b0; stale_ack = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rm_req", 32'(mem_req), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_pos", 32'(pos), 32'd0);
        chk("rm_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        mv0 = mv_count;
        @(negedge clk) stale_ack = 1'b1;
        @(negedge clk) stale_ack = 1'b0;
        repeat (5) @(negedge clk);
        chk("stale_busy", 32'(busy), 32'd0);
        chk("stale_mv", 32'(mv_count - mv0), 32'd0);
        chk("stale_mix", 32'(mix_out), 32'd0);
        resp_en = 1'b1;

        // recovery period
        lat = 2; play_mask = 4'b0100; rd_val[2] = -7;
        run_period("rec_timeout");
        chk("rec_mix", 32'(last_mix), 32'hFFF9);
        chk("rec_pos", 32'(pos), 32'd1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
